// File: rtl/sp_ram_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_bank_pkg
//  Description : Shared types and byte-lane merge helper for the bank array.
//  Revision    : 1.0 - initial release
// ============================================================================
package sp_ram_bank_pkg;

    typedef enum logic [1:0] {
        WM_READ_FIRST  = 2'd0,
        WM_WRITE_FIRST = 2'd1,
        WM_NO_CHANGE   = 2'd2
    } wr_mode_e;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_W  = 512;
    localparam int MERGE_IW = $clog2(MERGE_W);

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_word,
        input logic [MERGE_W-1:0] new_word,
        input logic [MERGE_W-1:0] lane_en,
        input int                 bw
    );
        logic [MERGE_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MERGE_W; i++) begin
            if (lane_en[MERGE_IW'(i / bw)]) begin
                res[MERGE_IW'(i)] = new_word[MERGE_IW'(i)];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_bank
//  Description : One single-port byte-enable RAM bank with input stage,
//                registered array read and optional output pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_bank
    import sp_ram_bank_pkg::*;
#(
    parameter int       AW            = 10,
    parameter int       DW            = 32,
    parameter int       BW            = 8,
    parameter int       OUT_REGS      = 1,
    parameter wr_mode_e MODE          = WM_READ_FIRST,
    parameter string    RAM_STYLE_VAL = "ultra"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [DW/BW-1:0]  be,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     din,
    input  logic              init_en,
    input  logic [AW-1:0]     init_addr,
    input  logic [DW-1:0]     init_data,
    output logic [DW-1:0]     dout,
    output logic              dout_vld
);

    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / BW;

    (* ram_style = RAM_STYLE_VAL *)
    logic [DW-1:0] mem [DEPTH];

    logic          s1_vld_q, s1_vld_d;
    logic          s1_we_q,  s1_we_d;
    logic [NB-1:0] s1_be_q,  s1_be_d;
    logic [AW-1:0] s1_addr_q, s1_addr_d;
    logic [DW-1:0] s1_din_q, s1_din_d;

    logic          s2_vld_q, s2_vld_d;
    logic [DW-1:0] s2_data_q, s2_data_d;

    logic [DW-1:0] w_old;
    logic [DW-1:0] w_merged;

    logic [OUT_REGS:0]         pipe_vld;
    logic [OUT_REGS:0][DW-1:0] pipe_data;

    always_comb begin
        s1_vld_d  = req;
        s1_we_d   = we;
        s1_be_d   = be;
        s1_addr_d = addr;
        s1_din_d  = din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_we_q   <= s1_we_d;
        s1_be_q   <= s1_be_d;
        s1_addr_q <= s1_addr_d;
        s1_din_q  <= s1_din_d;
    end

    assign w_old    = mem[s1_addr_q];
    assign w_merged = DW'(byte_merge(MERGE_W'(w_old), MERGE_W'(s1_din_q),
                                     MERGE_W'(s1_be_q), BW));

    // The init sweep owns the write port; user traffic cannot be in flight then.
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem[init_addr] <= init_data;
        end else if (s1_vld_q && s1_we_q) begin
            mem[s1_addr_q] <= w_merged;
        end
    end

    always_comb begin
        s2_vld_d  = s1_vld_q;
        s2_data_d = s2_data_q;
        if (s1_vld_q) begin
            if (!s1_we_q) begin
                s2_data_d = w_old;
            end else begin
                case (MODE)
                    WM_WRITE_FIRST: s2_data_d = w_merged;
                    WM_NO_CHANGE:   s2_data_d = s2_data_q;
                    default:        s2_data_d = w_old;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
        end else begin
            s2_vld_q  <= s2_vld_d;
            s2_data_q <= s2_data_d;
        end
    end

    assign pipe_vld[0]  = s2_vld_q;
    assign pipe_data[0] = s2_data_q;

    // Output stages load only on valid so dout holds between responses.
    for (genvar k = 1; k <= OUT_REGS; k++) begin : g_out
        logic          vld_q, vld_d;
        logic [DW-1:0] data_q, data_d;

        always_comb begin
            vld_d  = pipe_vld[k-1];
            data_d = pipe_vld[k-1] ? pipe_data[k-1] : data_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q  <= 1'b0;
                data_q <= '0;
            end else begin
                vld_q  <= vld_d;
                data_q <= data_d;
            end
        end

        assign pipe_vld[k]  = vld_q;
        assign pipe_data[k] = data_q;
    end

    assign dout     = pipe_data[OUT_REGS];
    assign dout_vld = pipe_vld[OUT_REGS];

endmodule
`default_nettype wire

// File: rtl/sp_ram_bank_array.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_bank_array
//  Description : Array of independent single-port RAM banks with a shared
//                power-up init sweep writing INIT_VAL to every address.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_bank_array
    import sp_ram_bank_pkg::*;
#(
    parameter int             NUM_RAMS      = 4,
    parameter int             AW            = 10,
    parameter int             DW            = 32,
    parameter int             BW            = 8,
    parameter int             OUT_REGS      = 1,
    parameter string          WR_MODE       = "READ_FIRST",
    parameter string          RAM_STYLE_VAL = "ultra",
    parameter logic [DW-1:0]  INIT_VAL      = '1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_RAMS-1:0]                req,
    input  logic [NUM_RAMS-1:0]                we,
    input  logic [NUM_RAMS-1:0][DW/BW-1:0]     be,
    input  logic [NUM_RAMS-1:0][AW-1:0]        addr,
    input  logic [NUM_RAMS-1:0][DW-1:0]        din,
    output logic [NUM_RAMS-1:0][DW-1:0]        dout,
    output logic [NUM_RAMS-1:0]                dout_vld,
    output logic                               init_busy
);

    localparam wr_mode_e MODE = (WR_MODE == "WRITE_FIRST") ? WM_WRITE_FIRST :
                                (WR_MODE == "NO_CHANGE")   ? WM_NO_CHANGE   :
                                                             WM_READ_FIRST;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          w_init_en;
    logic [NUM_RAMS-1:0] w_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + AW'(1);
            if (&cnt_q) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign w_init_en = (state_q == ST_INIT);
    assign init_busy = w_init_en;
    assign w_req     = w_init_en ? '0 : req;

    for (genvar i = 0; i < NUM_RAMS; i++) begin : g_bank
        sp_ram_bank #(
            .AW            (AW),
            .DW            (DW),
            .BW            (BW),
            .OUT_REGS      (OUT_REGS),
            .MODE          (MODE),
            .RAM_STYLE_VAL (RAM_STYLE_VAL)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .req       (w_req[i]),
            .we        (we[i]),
            .be        (be[i]),
            .addr      (addr[i]),
            .din       (din[i]),
            .init_en   (w_init_en),
            .init_addr (cnt_q),
            .init_data (INIT_VAL),
            .dout      (dout[i]),
            .dout_vld  (dout_vld[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_bank_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sp_ram_bank_array
//  Description : Scoreboard bench running READ_FIRST, WRITE_FIRST and
//                NO_CHANGE instances side by side on shared stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_bank_array;

    localparam int N   = 4;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int LAT = 3;   // 2 + OUT_REGS

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]         req = '0;
    logic [N-1:0]         we  = '0;
    logic [N-1:0][3:0]    be  = '0;
    logic [N-1:0][AW-1:0] addr = '0;
    logic [N-1:0][DW-1:0] din = '0;

    logic [N-1:0][DW-1:0] dout_m [3];
    logic [N-1:0]         vld_m  [3];
    logic                 busy_m [3];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mdl [N][16];
    logic [31:0] last_nc [N];
    exp_t        exp_q [3*N][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sp_ram_bank_array #(.NUM_RAMS(N), .AW(AW), .DW(DW), .BW(8), .OUT_REGS(1),
                        .WR_MODE("READ_FIRST")) u_rf (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout_m[0]), .dout_vld(vld_m[0]), .init_busy(busy_m[0]));

    sp_ram_bank_array #(.NUM_RAMS(N), .AW(AW), .DW(DW), .BW(8), .OUT_REGS(1),
                        .WR_MODE("WRITE_FIRST")) u_wf (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout_m[1]), .dout_vld(vld_m[1]), .init_busy(busy_m[1]));

    sp_ram_bank_array #(.NUM_RAMS(N), .AW(AW), .DW(DW), .BW(8), .OUT_REGS(1),
                        .WR_MODE("NO_CHANGE")) u_nc (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout_m[2]), .dout_vld(vld_m[2]), .init_busy(busy_m[2]));

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  lanes);
        logic [31:0] r;
        r = old_w;
        for (int j = 0; j < 4; j++) begin
            if (lanes[j]) r[8*j +: 8] = new_w[8*j +: 8];
        end
        return r;
    endfunction

    // Reference: sequential memory per bank; expected response per mode.
    task automatic issue();
        logic [31:0] old_w, new_w, nc_w;
        for (int b = 0; b < N; b++) begin
            if (req[b]) begin
                old_w = mdl[b][addr[b]];
                new_w = merge(old_w, din[b], be[b]);
                if (we[b]) mdl[b][addr[b]] = new_w;
                nc_w = we[b] ? last_nc[b] : old_w;
                last_nc[b] = nc_w;
                exp_q[b].push_back('{old_w, cyc});
                exp_q[N + b].push_back('{(we[b] ? new_w : old_w), cyc});
                exp_q[2*N + b].push_back('{nc_w, cyc});
            end
        end
    endtask

    task automatic step(input bit push);
        if (push) issue();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int m = 0; m < 3; m++) begin
                for (int b = 0; b < N; b++) begin
                    if (vld_m[m][b]) begin
                        checks++;
                        if (exp_q[m*N + b].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_vld dut%0d bank%0d dout=%h at cycle %0d",
                                     m, b, dout_m[m][b], cyc);
                        end else begin
                            e = exp_q[m*N + b].pop_front();
                            if (dout_m[m][b] !== e.data || cyc != e.cyc + LAT) begin
                                errors++;
                                $display("FAIL dout dut%0d bank%0d got=%h exp=%h cycle=%0d exp_cycle=%0d",
                                         m, b, dout_m[m][b], e.data, cyc, e.cyc + LAT);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (busy_m[m] !== 1'b1 || vld_m[m] !== '0 || dout_m[m] !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d busy=%b vld=%b dout=%h exp busy=1 vld=0 dout=0",
                         m, busy_m[m], vld_m[m], dout_m[m]);
            end
        end
        for (int q = 0; q < 3*N; q++) exp_q[q].delete();
        for (int b = 0; b < N; b++) last_nc[b] = '0;
    endtask

    task automatic run_sweep(input bit hold_req, input string name);
        int n;
        n = 0;
        while (busy_m[0] && n < 100) begin
            if (hold_req) begin
                req = '1;
                we  = '1;
                be  = '1;
                for (int b = 0; b < N; b++) begin
                    addr[b] = AW'($urandom_range(0, 15));
                    din[b]  = $urandom;
                end
            end
            step(1'b0);
            n++;
        end
        req = '0;
        we  = '0;
        for (int b = 0; b < N; b++)
            for (int a = 0; a < 16; a++) mdl[b][a] = 32'hFFFF_FFFF;
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL %s busy_cycles got=%0d exp=16", name, n);
        end
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (busy_m[m] !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_after dut%0d got=%b exp=0", name, m, busy_m[m]);
            end
        end
    endtask

    initial begin
        apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_sweep(1'b0, "sweep1");

        // Reset landing mid-sweep restarts the sweep from address 0.
        apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 7; k++) step(1'b0);
        apply_reset();
        #1;
        rst = 1'b0;
        run_sweep(1'b1, "sweep_restart");

        for (int a = 0; a < 16; a++) begin
            req = '1;
            we  = '0;
            for (int b = 0; b < N; b++) addr[b] = AW'(a);
            step(1'b1);
        end

        req = 4'b0001; we = 4'b0001;
        be[0] = 4'b0101; addr[0] = 4'h3; din[0] = 32'h1234_5678;
        step(1'b1);
        we = '0;
        step(1'b1);

        req = '1; we = '1; be = '1;
        for (int b = 0; b < N; b++) begin
            addr[b] = 4'h5;
            din[b]  = 32'hC0DE_0000 + 32'(b * 17 + 1);
        end
        step(1'b1);
        we = '0;
        step(1'b1);

        for (int b = 0; b < N; b++) begin
            addr[b] = 4'h9;
            din[b]  = 32'h5;
        end
        we = '1;
        step(1'b1);
        for (int b = 0; b < N; b++) din[b] = 32'hA;
        step(1'b1);
        we = '0;
        step(1'b1);

        for (int k = 0; k < 400; k++) begin
            req = N'($urandom);
            we  = N'($urandom);
            for (int b = 0; b < N; b++) begin
                be[b]   = 4'($urandom);
                addr[b] = AW'($urandom_range(0, 3));
                din[b]  = $urandom;
            end
            step(1'b1);
        end
        req = '0;
        we  = '0;
        for (int k = 0; k < 10; k++) step(1'b0);

        for (int q = 0; q < 3*N; q++) begin
            checks++;
            if (exp_q[q].size() != 0) begin
                errors++;
                $display("FAIL drain queue%0d pending=%0d exp=0", q, exp_q[q].size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
